// File: rtl/rect_ctl_pkg.sv
// Shared state encoding and default parameters for the falling-rectangle controller.
package rect_ctl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FALL   = 2'd1,
        ST_RISE   = 2'd2,
        ST_LANDED = 2'd3
    } rect_state_e;

    localparam int DEF_COORD_W      = 12;
    localparam int DEF_VEL_W        = 12;
    localparam int DEF_SCREEN_H     = 600;
    localparam int DEF_RECT_H       = 48;
    localparam int DEF_FRAME_DIV    = 40000;
    localparam int DEF_G_ACCEL      = 1;
    localparam int DEF_BOUNCE_SHIFT = 0;

endpackage

// File: rtl/frame_tick_gen.sv
// Physics tick: one-cycle strobe every FRAME_DIV clocks, restartable via clr.
module frame_tick_gen
    import rect_ctl_pkg::*;
#(
    parameter int FRAME_DIV = DEF_FRAME_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (FRAME_DIV > 2) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CNT_W-1:0] TC = CNT_W'(FRAME_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == TC);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rect_drop_ctl.sv
// Rectangle follows the mouse until clicked, then falls under gravity with optional bounce.
//   state     | meaning
//   ST_IDLE   | position tracks mouse, waiting for a click
//   ST_FALL   | accelerating downward each tick
//   ST_RISE   | decelerating upward after a bounce
//   ST_LANDED | resting on the floor until the next click
module rect_drop_ctl
    import rect_ctl_pkg::*;
#(
    parameter int COORD_W      = DEF_COORD_W,
    parameter int VEL_W        = DEF_VEL_W,
    parameter int SCREEN_H     = DEF_SCREEN_H,
    parameter int RECT_H       = DEF_RECT_H,
    parameter int FRAME_DIV    = DEF_FRAME_DIV,
    parameter int G_ACCEL      = DEF_G_ACCEL,
    parameter int BOUNCE_SHIFT = DEF_BOUNCE_SHIFT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COORD_W-1:0] mouse_xpos,
    input  logic [COORD_W-1:0] mouse_ypos,
    input  logic               mouse_left,
    output logic [COORD_W-1:0] xpos,
    output logic [COORD_W-1:0] ypos,
    output logic               busy,
    output logic               landed
);

    localparam int SUM_W = COORD_W + 1;
    localparam logic [COORD_W-1:0] FLOOR_C = COORD_W'(SCREEN_H - RECT_H);
    localparam logic [VEL_W-1:0]   VEL_MAX = {VEL_W{1'b1}};
    localparam logic [VEL_W-1:0]   G_V     = VEL_W'(G_ACCEL);

    rect_state_e        state_q, state_d;
    logic [COORD_W-1:0] xpos_q, xpos_d, ypos_q, ypos_d;
    logic [VEL_W-1:0]   vel_q, vel_d;
    logic               btn_q;
    logic               busy_q, busy_d, landed_q, landed_d;

    logic               click, tick, tick_clr, hit;
    logic [VEL_W:0]     v_inc;
    logic [VEL_W-1:0]   v_new, v_bnc;
    logic [SUM_W-1:0]   y_sum, y_diff;

    assign click    = mouse_left & ~btn_q;
    assign tick_clr = (state_q == ST_IDLE) || (state_q == ST_LANDED);

    frame_tick_gen #(.FRAME_DIV(FRAME_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tick_clr),
        .tick  (tick)
    );

    // Extra headroom bit keeps the floor compare and the rise underflow free of wrap-around.
    assign v_inc  = {1'b0, vel_q} + {1'b0, G_V};
    assign v_new  = v_inc[VEL_W] ? VEL_MAX : v_inc[VEL_W-1:0];
    assign v_bnc  = v_new >> BOUNCE_SHIFT;
    assign y_sum  = {1'b0, ypos_q} + SUM_W'(v_new);
    assign hit    = (y_sum >= {1'b0, FLOOR_C});
    assign y_diff = {1'b0, ypos_q} - SUM_W'(vel_q);

    always_comb begin
        state_d = state_q;
        xpos_d  = xpos_q;
        ypos_d  = ypos_q;
        vel_d   = vel_q;
        case (state_q)
            ST_IDLE: begin
                xpos_d = mouse_xpos;
                ypos_d = mouse_ypos;
                if (click) begin
                    state_d = ST_FALL;
                    vel_d   = '0;
                end
            end
            ST_FALL: begin
                if (tick) begin
                    if (hit) begin
                        ypos_d = FLOOR_C;
                        if (BOUNCE_SHIFT == 0 || v_bnc == '0) begin
                            state_d = ST_LANDED;
                            vel_d   = '0;
                        end else begin
                            state_d = ST_RISE;
                            vel_d   = v_bnc;
                        end
                    end else begin
                        ypos_d = y_sum[COORD_W-1:0];
                        vel_d  = v_new;
                    end
                end
            end
            ST_RISE: begin
                if (tick) begin
                    ypos_d = y_diff[COORD_W] ? '0 : y_diff[COORD_W-1:0];
                    if (vel_q <= G_V) begin
                        state_d = ST_FALL;
                        vel_d   = '0;
                    end else begin
                        vel_d = vel_q - G_V;
                    end
                end
            end
            ST_LANDED: begin
                if (click) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d   = (state_d == ST_FALL) || (state_d == ST_RISE);
        landed_d = (state_d == ST_LANDED) && (state_q != ST_LANDED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            xpos_q   <= '0;
            ypos_q   <= '0;
            vel_q    <= '0;
            btn_q    <= 1'b0;
            busy_q   <= 1'b0;
            landed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            xpos_q   <= xpos_d;
            ypos_q   <= ypos_d;
            vel_q    <= vel_d;
            btn_q    <= mouse_left;
            busy_q   <= busy_d;
            landed_q <= landed_d;
        end
    end

    assign xpos   = xpos_q;
    assign ypos   = ypos_q;
    assign busy   = busy_q;
    assign landed = landed_q;

endmodule

// File: tb/tb_rect_drop_ctl.sv
// Directed bench: two controllers (no bounce / half bounce) share the same mouse stimulus.
module tb_rect_drop_ctl;

    logic        clk;
    logic        rst_n;
    logic [11:0] mouse_x, mouse_y;
    logic        left;
    logic [11:0] x0, y0, x1, y1;
    logic        busy0, landed0, busy1, landed1;

    int n_chk = 0;
    int n_err = 0;

    rect_drop_ctl #(
        .COORD_W(12), .VEL_W(12), .SCREEN_H(120), .RECT_H(20),
        .FRAME_DIV(4), .G_ACCEL(1), .BOUNCE_SHIFT(0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .mouse_xpos(mouse_x), .mouse_ypos(mouse_y),
        .mouse_left(left), .xpos(x0), .ypos(y0), .busy(busy0), .landed(landed0)
    );

    rect_drop_ctl #(
        .COORD_W(12), .VEL_W(12), .SCREEN_H(120), .RECT_H(20),
        .FRAME_DIV(4), .G_ACCEL(1), .BOUNCE_SHIFT(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .mouse_xpos(mouse_x), .mouse_ypos(mouse_y),
        .mouse_left(left), .xpos(x1), .ypos(y1), .busy(busy1), .landed(landed1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic click_pulse();
        left = 1'b1;
        step();
        left = 1'b0;
    endtask

    int seq0 [4]  = '{91, 93, 96, 100};
    int seq1 [10] = '{91, 93, 96, 100, 98, 97, 98, 100, 99, 100};

    initial begin
        rst_n   = 1'b0;
        mouse_x = '0;
        mouse_y = '0;
        left    = 1'b0;
        step();
        step();
        chk("rst_x", x0, 0);
        chk("rst_y", y0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_landed", landed0, 0);
        rst_n = 1'b1;

        // idle tracking, one cycle latency
        mouse_x = 12'd30;
        mouse_y = 12'd40;
        step();
        chk("trk_x", x0, 30);
        chk("trk_y", y0, 40);

        // plain fall, button held throughout, mouse moved while falling
        mouse_x = 12'd50;
        mouse_y = 12'd90;
        step();
        left = 1'b1;
        step();
        chk("fall_busy_start", busy0, 1);
        chk("fall_x_start", x0, 50);
        mouse_x = 12'd200;
        mouse_y = 12'd10;
        for (int i = 0; i < 4; i++) begin
            repeat (4) step();
            chk($sformatf("fall_y%0d", i), y0, seq0[i]);
            if (i < 3) begin
                chk($sformatf("fall_busy%0d", i), busy0, 1);
                chk($sformatf("fall_x%0d", i), x0, 50);
            end else begin
                chk("fall_landed_pulse", landed0, 1);
                chk("fall_busy_end", busy0, 0);
            end
        end
        step();
        chk("landed_one_cycle", landed0, 0);
        repeat (6) step();
        chk("held_y", y0, 100);
        chk("held_x", x0, 50);
        chk("held_landed", landed0, 0);
        chk("held_busy", busy0, 0);
        left = 1'b0;
        step();
        click_pulse();
        chk("relaunch_hold_y", y0, 100);
        step();
        chk("resume_y", y0, 10);
        chk("resume_x", x0, 200);
        chk("resume_busy", busy0, 0);

        // bounce trajectory with stray clicks while busy
        rst_n = 1'b0;
        step();
        rst_n   = 1'b1;
        mouse_x = 12'd60;
        mouse_y = 12'd90;
        step();
        click_pulse();
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 4; j++) begin
                left = (j == 1 && (i == 1 || i == 4 || i == 7));
                step();
                if (i == 0 && j == 2) chk("bnc_no_early_tick", y1, 90);
            end
            left = 1'b0;
            chk($sformatf("bnc_y%0d", i), y1, seq1[i]);
            if (i < 9) chk($sformatf("bnc_busy%0d", i), busy1, 1);
        end
        chk("bnc_landed", landed1, 1);
        chk("bnc_busy_end", busy1, 0);
        chk("bnc_x", x1, 60);

        // click below the floor clamps on the first tick
        rst_n = 1'b0;
        step();
        rst_n   = 1'b1;
        mouse_x = 12'd70;
        mouse_y = 12'd110;
        step();
        chk("low_y_idle", y0, 110);
        click_pulse();
        repeat (4) step();
        chk("low_y0", y0, 100);
        chk("low_landed0", landed0, 1);
        chk("low_busy0", busy0, 0);
        chk("low_y1", y1, 100);
        chk("low_landed1", landed1, 1);

        // asynchronous reset mid-fall
        rst_n = 1'b0;
        step();
        rst_n   = 1'b1;
        mouse_x = 12'd5;
        mouse_y = 12'd20;
        step();
        click_pulse();
        repeat (6) step();
        chk("mid_busy", busy0, 1);
        chk("mid_y", y0, 21);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_x", x0, 0);
        chk("arst_y", y0, 0);
        chk("arst_busy0", busy0, 0);
        chk("arst_busy1", busy1, 0);
        mouse_x = 12'd30;
        mouse_y = 12'd40;
        #1;
        rst_n = 1'b1;
        step();
        chk("post_rst_x", x0, 30);
        chk("post_rst_y", y0, 40);
        chk("post_rst_busy", busy0, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
